// File: rtl/inst_sram_pkg.sv
// inst_sram_pkg: shared constants, FSM state type and clog2 helper for the instruction SRAM responder
package inst_sram_pkg;
    localparam logic [31:0] RESET_VECTOR = 32'hbfc00000;
    localparam logic [31:0] NOP_WORD     = 32'h00000000;

    typedef enum logic {ST_INIT, ST_READY} state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction
endpackage

// File: rtl/inst_sram_rd_pipe.sv
// inst_sram_rd_pipe: STAGES-deep flushable delay line for the read response payload
//   clk   clock
//   rst   synchronous active-high flush
//   d     payload entering the line
//   q     payload leaving the line (equals d when STAGES=0)
module inst_sram_rd_pipe #(
    parameter int STAGES = 0,
    parameter int W      = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    if (STAGES == 0) begin : g_bypass
        logic unused_ok;
        assign unused_ok = &{1'b0, clk, rst};
        assign q = d;
    end else begin : g_pipe
        logic [W-1:0] r [STAGES];
        always_ff @(posedge clk) begin
            if (rst) begin
                for (int i = 0; i < STAGES; i++) r[i] <= '0;
            end else begin
                r[0] <= d;
                for (int i = 1; i < STAGES; i++) r[i] <= r[i-1];
            end
        end
        assign q = r[STAGES-1];
    end
endmodule

// File: rtl/inst_sram_responder.sv
// inst_sram_responder: instruction-SRAM fetch responder with post-reset sweep and byte-strobed loader
//   clk, resetn (active-high sync reset despite the name)
//   inst_sram_en/addr          fetch request from the PC stage
//   inst_sram_rdata/rvalid/fault  response READ_LATENCY cycles after the request
//   ld_we/ld_addr/ld_wdata/ld_wstrb  loader write port (word index, byte strobes)
//   init_done                  sweep complete, serving requests
//   parity_err                 only when INST_SRAM_PARITY_EN is defined: stored parity mismatch
module inst_sram_responder
    import inst_sram_pkg::*;
#(
    parameter int          DEPTH        = 1024,
    parameter logic [31:0] BASE_ADDR    = RESET_VECTOR,
    parameter int          READ_LATENCY = 1,
    parameter logic [31:0] INIT_WORD    = NOP_WORD,
    localparam int         ADDR_W       = clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              inst_sram_en,
    input  logic [31:0]       inst_sram_addr,
    output logic [31:0]       inst_sram_rdata,
    output logic              inst_sram_rvalid,
    output logic              inst_sram_fault,
    input  logic              ld_we,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [31:0]       ld_wdata,
    input  logic [3:0]        ld_wstrb,
    output logic              init_done
`ifdef INST_SRAM_PARITY_EN
    ,
    output logic              parity_err
`endif
);
`ifdef INST_SRAM_PARITY_EN
    localparam int MW = 33;
    function automatic logic [MW-1:0] enc(input logic [31:0] w);
        return {^w, w};
    endfunction
`else
    localparam int MW = 32;
    function automatic logic [MW-1:0] enc(input logic [31:0] w);
        return w;
    endfunction
`endif
    localparam logic [31:0] SPAN = 32'(4 * DEPTH);
    localparam int          PW   = MW + 2;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] cnt;
    logic [MW-1:0]     mem [DEPTH];
    logic [31:0]       offset, merged;
    logic [ADDR_W-1:0] idx;
    logic              hit, req;
    logic              s1_valid, s1_fault;
    logic [31:0]       s1_data;
    logic [PW-1:0]     s1, p;

    always_ff @(posedge clk) begin
        if (resetn) begin
            state <= ST_INIT;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= (state == ST_INIT) ? cnt + 1'b1 : cnt;
        end
    end

    always_comb begin
        state_nxt = (state == ST_INIT && cnt == ADDR_W'(DEPTH - 1)) ? ST_READY : state;
    end

    assign init_done = (state == ST_READY);
    // Unsigned subtraction makes addresses below the base wrap high, so one compare covers both bounds.
    assign offset    = inst_sram_addr - BASE_ADDR;
    assign hit       = (inst_sram_addr[1:0] == 2'b00) && (offset < SPAN);
    assign idx       = offset[ADDR_W+1:2];
    assign req       = inst_sram_en && init_done;

    always_comb begin
        merged = mem[ld_addr][31:0];
        for (int i = 0; i < 4; i++) merged[8*i+:8] = ld_wstrb[i] ? ld_wdata[8*i+:8] : merged[8*i+:8];
    end

    always_ff @(posedge clk) begin
        if (!resetn && state == ST_INIT)
            mem[cnt] <= enc(INIT_WORD);
        else if (!resetn && init_done && ld_we)
            mem[ld_addr] <= enc(merged);
    end

    // Data only updates on a request so idle cycles keep presenting the last returned word.
    always_ff @(posedge clk) begin
        if (resetn) begin
            s1_valid <= 1'b0;
            s1_fault <= 1'b0;
            s1_data  <= '0;
        end else begin
            s1_valid <= req;
            s1_fault <= req && !hit;
            if (req) s1_data <= hit ? mem[idx][31:0] : '0;
        end
    end

`ifdef INST_SRAM_PARITY_EN
    logic s1_perr;
    always_ff @(posedge clk) begin
        if (resetn) s1_perr <= 1'b0;
        else        s1_perr <= req && hit && (^mem[idx]);
    end
    assign s1         = {s1_perr, s1_fault, s1_valid, s1_data};
    assign parity_err = p[34];
`else
    assign s1 = {s1_fault, s1_valid, s1_data};
`endif

    inst_sram_rd_pipe #(.STAGES(READ_LATENCY - 1), .W(PW)) u_rd_pipe (
        .clk (clk),
        .rst (resetn),
        .d   (s1),
        .q   (p)
    );

    assign inst_sram_rdata  = p[31:0];
    assign inst_sram_rvalid = p[32];
    assign inst_sram_fault  = p[33];
endmodule

// File: tb/tb_inst_sram_responder.sv
// tb_inst_sram_responder: randomized scoreboard bench for inst_sram_responder
module tb_inst_sram_responder;
    localparam int          DEPTH = 256;
    localparam int          LAT   = 3;
    localparam int          AW    = 8;
    localparam logic [31:0] BASE  = 32'hbfc00000;

    logic          clk = 1'b0, resetn = 1'b1, en = 1'b0, ld_we = 1'b0;
    logic [31:0]   addr = '0, ld_wdata = '0;
    logic [AW-1:0] ld_addr = '0;
    logic [3:0]    ld_wstrb = '0;
    logic [31:0]   rdata;
    logic          rvalid, fault, init_done;
`ifdef INST_SRAM_PARITY_EN
    logic          parity_err;
`endif

    always #5 clk = ~clk;

    inst_sram_responder #(.DEPTH(DEPTH), .READ_LATENCY(LAT)) dut (
        .clk              (clk),
        .resetn           (resetn),
        .inst_sram_en     (en),
        .inst_sram_addr   (addr),
        .inst_sram_rdata  (rdata),
        .inst_sram_rvalid (rvalid),
        .inst_sram_fault  (fault),
        .ld_we            (ld_we),
        .ld_addr          (ld_addr),
        .ld_wdata         (ld_wdata),
        .ld_wstrb         (ld_wstrb),
        .init_done        (init_done)
`ifdef INST_SRAM_PARITY_EN
        ,
        .parity_err       (parity_err)
`endif
    );

    typedef struct {
        logic [31:0] d;
        logic        f;
        logic        p;
        int          cyc;
    } exp_t;

    exp_t        q[$];
    logic [31:0] ref_mem [DEPTH];
    logic        bad [DEPTH];
    int          cyc = 0, checks = 0, errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic is_fault(input logic [31:0] a);
        return (a % 4 != 0) || (64'(a) < 64'(BASE)) || (64'(a) >= 64'(BASE) + 64'(4 * DEPTH));
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic e, input logic [31:0] a, input logic w,
                         input logic [AW-1:0] la, input logic [31:0] wd, input logic [3:0] ws);
        exp_t x;
        int   i;
        en = e; addr = a; ld_we = w; ld_addr = la; ld_wdata = wd; ld_wstrb = ws;
        if (init_done && e) begin
            x.f   = is_fault(a);
            i     = x.f ? 0 : int'((64'(a) - 64'(BASE)) / 4);
            x.d   = x.f ? 32'h0 : ref_mem[i];
            x.p   = !x.f && bad[i];
            x.cyc = cyc + LAT;
            q.push_back(x);
        end
        if (init_done && w) begin
            for (int b = 0; b < 4; b++) if (ws[b]) ref_mem[la][8*b+:8] = wd[8*b+:8];
            bad[la] = 1'b0;
        end
        step();
        en = 1'b0;
        ld_we = 1'b0;
    endtask

    function automatic logic [31:0] rand_addr();
        int k;
        k = int'($urandom_range(0, 9));
        if (k == 0) return BASE + 4 * $urandom_range(0, DEPTH - 1) + $urandom_range(1, 3);
        if (k == 1) return BASE - 4 * $urandom_range(1, 4);
        if (k == 2) return BASE + 4 * DEPTH + 4 * $urandom_range(0, 3);
        if (k == 3) return $urandom;
        return BASE + 4 * $urandom_range(0, DEPTH - 1);
    endfunction

    task automatic rand_cycle();
        drive($urandom_range(0, 3) != 0, rand_addr(), $urandom_range(0, 2) == 0,
              AW'($urandom), $urandom, 4'($urandom));
    endtask

    task automatic do_reset(input int n);
        int c;
        resetn = 1'b1;
        repeat (n) rand_cycle();
        chk("reset_rvalid", 32'(rvalid), 32'h0);
        chk("reset_rdata", rdata, 32'h0);
        chk("reset_fault", 32'(fault), 32'h0);
        chk("reset_init_done", 32'(init_done), 32'h0);
        for (int i = 0; i < DEPTH; i++) begin
            ref_mem[i] = 32'h0;
            bad[i] = 1'b0;
        end
        resetn = 1'b0;
        c = 0;
        while (!init_done && c < DEPTH + 8) begin
            rand_cycle();
            c++;
        end
        chk("init_done_cycles", 32'(c), 32'(DEPTH));
    endtask

    logic        rst_prev = 1'b0;
    logic [31:0] last = '0;
    initial begin
        exp_t x;
        @(posedge clk);
        forever begin
            @(negedge clk);
            if (rst_prev) begin
                q.delete();
                last = '0;
            end
            rst_prev = resetn;
            if (rvalid) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rvalid: got rvalid=1 rdata=%h expected no response (cycle %0d)", rdata, cyc);
                end else begin
                    x = q.pop_front();
                    chk("rdata", rdata, x.d);
                    chk("fault", 32'(fault), 32'(x.f));
                    chk("latency_cycle", 32'(cyc), 32'(x.cyc));
`ifdef INST_SRAM_PARITY_EN
                    chk("parity_err", 32'(parity_err), 32'(x.p));
`endif
                end
                last = rdata;
            end else begin
                chk("idle_fault", 32'(fault), 32'h0);
                chk("idle_rdata_hold", rdata, last);
                if (q.size() != 0 && q[0].cyc <= cyc) begin
                    x = q.pop_front();
                    checks++;
                    errors++;
                    $display("FAIL missing_rvalid: got rvalid=0 expected response %h (cycle %0d)", x.d, cyc);
                end
            end
        end
    end

    initial begin
        do_reset(3);
        drive(0, 0, 1, 0, 32'h24080001, 4'hf);
        drive(1, BASE, 0, 0, 0, 0);
        repeat (LAT + 1) step();
        drive(1, BASE, 0, 0, 0, 0);
        drive(1, BASE + 4, 0, 0, 0, 0);
        drive(1, BASE + 8, 0, 0, 0, 0);
        drive(0, 0, 1, 3, 32'h11223344, 4'hf);
        drive(0, 0, 1, 3, 32'h0000AB00, 4'b0010);
        drive(1, BASE + 12, 0, 0, 0, 0);
        drive(1, BASE + 2, 0, 0, 0, 0);
        drive(1, BASE + 4 * DEPTH, 0, 0, 0, 0);
        drive(1, 32'hbfbffffc, 0, 0, 0, 0);
        drive(1, BASE + 4 * (DEPTH - 1), 0, 0, 0, 0);
        drive(0, 0, 1, 5, 32'hcafef00d, 4'hf);
        drive(1, BASE + 20, 1, 5, 32'h12345678, 4'hf);
        drive(1, BASE + 20, 0, 0, 0, 0);
        drive(0, 0, 1, 5, 32'hffffffff, 4'h0);
        drive(1, BASE + 20, 0, 0, 0, 0);
`ifdef INST_SRAM_PARITY_EN
        drive(0, 0, 1, 7, 32'h0f0f1234, 4'hf);
        step();
        dut.mem[7] = dut.mem[7] ^ 33'h1;
        ref_mem[7] = ref_mem[7] ^ 32'h1;
        bad[7] = 1'b1;
        drive(1, BASE + 28, 0, 0, 0, 0);
`endif
        repeat (1500) rand_cycle();
        repeat (LAT + 2) step();
        drive(0, 0, 1, 5, 32'hdeadbeef, 4'hf);
        drive(1, BASE + 20, 0, 0, 0, 0);
        drive(1, BASE + 24, 0, 0, 0, 0);
        do_reset(1);
        drive(1, BASE + 20, 0, 0, 0, 0);
        repeat (300) rand_cycle();
        repeat (LAT + 3) step();
        chk("queue_drained", 32'(q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
